// File: rtl/ctrl_pkg.sv
// Shared constants, control bundle type and opcode decode helpers for control_unit_mc.
package ctrl_pkg;

  localparam logic [6:0] ALU_R     = 7'b0110011;
  localparam logic [6:0] ALU_I     = 7'b0010011;
  localparam logic [6:0] BRANCH_EQ = 7'b1100011;
  localparam logic [6:0] JUMP      = 7'b1101111;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;

  localparam logic [1:0] ADD_OPCODE    = 2'b00;
  localparam logic [1:0] SUB_OPCODE    = 2'b01;
  localparam logic [1:0] R_TYPE_OPCODE = 2'b10;

  localparam logic [6:0] FUNCT7_MUL = 7'b0000001;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       branch;
    logic       mem_read;
    logic       mem_2_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       jump;
  } ctrl_bundle_t;

  // Unknown opcodes still drive alu_op=R_TYPE so the ALU sees a defined operation.
  function automatic ctrl_bundle_t decode_opcode(input logic [6:0] op);
    ctrl_bundle_t b;
    b = '0;
    case (op)
      ALU_R: begin
        b.alu_op    = R_TYPE_OPCODE;
        b.reg_write = 1'b1;
      end
      ALU_I: begin
        b.alu_op    = ADD_OPCODE;
        b.alu_src   = 1'b1;
        b.reg_write = 1'b1;
      end
      BRANCH_EQ: begin
        b.alu_op = SUB_OPCODE;
        b.branch = 1'b1;
      end
      JUMP: begin
        b.mem_2_reg = 1'b1;
        b.reg_write = 1'b1;
        b.jump      = 1'b1;
      end
      LOAD: begin
        b.alu_src   = 1'b1;
        b.mem_2_reg = 1'b1;
        b.reg_write = 1'b1;
        b.mem_read  = 1'b1;
      end
      STORE: begin
        b.alu_src   = 1'b1;
        b.mem_write = 1'b1;
      end
      default: b.alu_op = R_TYPE_OPCODE;
    endcase
    return b;
  endfunction

  function automatic logic is_legal_opcode(input logic [6:0] op);
    return (op == ALU_R) || (op == ALU_I) || (op == BRANCH_EQ) ||
           (op == JUMP)  || (op == LOAD)  || (op == STORE);
  endfunction

endpackage

// File: rtl/mul_seq_fsm.sv
// Multiplier sequencer: IDLE/BUSY FSM with a down-counter over the extra MUL cycles.
module mul_seq_fsm
  import ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = 4
) (
  input  logic clk,
  input  logic arst,
  input  logic start,
  input  logic flush,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(MUL_LATENCY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  mul_state_t    state_reg;
  logic [CW-1:0] cnt_reg;
  logic          single_reg;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      single_reg <= 1'b0;
    end else if (flush) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      single_reg <= 1'b0;
    end else begin
      // A one-cycle multiplier never enters BUSY; done pulses alongside mul_start.
      single_reg <= (MUL_LATENCY == 1) && start;
      if (start && (MUL_LATENCY > 1)) begin
        state_reg <= BUSY;
        cnt_reg   <= CNT_LOAD;
      end else if (state_reg == BUSY) begin
        if (cnt_reg == CNT_ONE) begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg - CNT_ONE;
        end
      end
    end
  end

  assign busy = (state_reg == BUSY);
  assign done = (busy && (cnt_reg == CNT_ONE)) || single_reg;

endmodule

// File: rtl/control_unit_mc.sv
// Registered main decoder feeding ID/EX, with multi-cycle MUL sequencing.
// Optional MUL support is enabled by defining RV_MUL_EXT_EN.
module control_unit_mc
  import ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = 4
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       en,
  input  logic       flush,
  input  logic       insert_bubble,
  input  logic [6:0] opcode,
  input  logic [6:0] funct7,
  output logic [1:0] alu_op,
  output logic       branch,
  output logic       mem_read,
  output logic       mem_2_reg,
  output logic       mem_write,
  output logic       alu_src,
  output logic       reg_write,
  output logic       jump,
  output logic       valid_ex,
  output logic       illegal,
  output logic       mul_start,
  output logic       mul_done,
  output logic       stall
);

  ctrl_bundle_t bundle_reg;
  ctrl_bundle_t dec_bundle;
  logic         dec_legal;
  logic         valid_reg;
  logic         illegal_reg;
  logic         mul_start_reg;
  logic         is_mul;
  logic         fsm_busy;
  logic         fsm_done;
  logic         hold;

  assign dec_bundle = decode_opcode(opcode);
  assign dec_legal  = is_legal_opcode(opcode);

`ifdef RV_MUL_EXT_EN
  logic fsm_start;

  assign is_mul    = (opcode == ALU_R) && (funct7 == FUNCT7_MUL);
  // Start only when the MUL is actually latched by the decode branch below.
  assign fsm_start = is_mul && !hold && en && !insert_bubble;

  mul_seq_fsm #(
    .MUL_LATENCY(MUL_LATENCY)
  ) u_mul_seq (
    .clk  (clk),
    .arst (arst),
    .start(fsm_start),
    .flush(flush),
    .busy (fsm_busy),
    .done (fsm_done)
  );
`else
  logic unused_funct7;

  assign unused_funct7 = ^funct7;
  assign is_mul        = 1'b0;
  assign fsm_busy      = 1'b0;
  assign fsm_done      = 1'b0;
`endif

  // The final BUSY cycle releases EX so the next instruction latches without a gap.
  assign hold = fsm_busy && !fsm_done;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      bundle_reg    <= '0;
      valid_reg     <= 1'b0;
      illegal_reg   <= 1'b0;
      mul_start_reg <= 1'b0;
    end else if (flush) begin
      bundle_reg    <= '0;
      valid_reg     <= 1'b0;
      illegal_reg   <= 1'b0;
      mul_start_reg <= 1'b0;
    end else if (hold || !en) begin
      illegal_reg   <= 1'b0;
      mul_start_reg <= 1'b0;
    end else if (insert_bubble) begin
      bundle_reg    <= '0;
      valid_reg     <= 1'b0;
      illegal_reg   <= 1'b0;
      mul_start_reg <= 1'b0;
    end else begin
      bundle_reg    <= dec_bundle;
      valid_reg     <= dec_legal;
      illegal_reg   <= !dec_legal;
      mul_start_reg <= is_mul;
    end
  end

  assign alu_op    = bundle_reg.alu_op;
  assign branch    = bundle_reg.branch;
  assign mem_read  = bundle_reg.mem_read;
  assign mem_2_reg = bundle_reg.mem_2_reg;
  assign mem_write = bundle_reg.mem_write;
  assign alu_src   = bundle_reg.alu_src;
  assign reg_write = bundle_reg.reg_write;
  assign jump      = bundle_reg.jump;
  assign valid_ex  = valid_reg;
  assign illegal   = illegal_reg;
  assign mul_start = mul_start_reg;
  assign mul_done  = fsm_done;
  assign stall     = fsm_busy;

endmodule

// File: tb/tb_control_unit_mc.sv
// Self-checking bench for control_unit_mc: per-cycle model compare plus literal pins.
module tb_control_unit_mc;

  localparam int L = 4;
`ifdef RV_MUL_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;
  localparam logic [6:0] F7_MUL = 7'b0000001;

  // Bundles in order {alu_src, mem_2_reg, reg_write, mem_read, mem_write, branch, alu_op, jump}
  localparam logic [8:0] B_R    = 9'b0_0_1_0_0_0_10_0;
  localparam logic [8:0] B_I    = 9'b1_0_1_0_0_0_00_0;
  localparam logic [8:0] B_LD   = 9'b1_1_1_1_0_0_00_0;
  localparam logic [8:0] B_ST   = 9'b1_0_0_0_1_0_00_0;
  localparam logic [8:0] B_BAD  = 9'b0_0_0_0_0_0_10_0;
  localparam logic [8:0] B_ZERO = 9'b0;

  logic       clk = 1'b0;
  logic       arst, en, flush, insert_bubble;
  logic [6:0] opcode, funct7;
  logic [1:0] alu_op;
  logic       branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write, jump;
  logic       valid_ex, illegal, mul_start, mul_done, stall;

  int passed = 0;
  int total  = 0;
  bit cmp_on = 1'b0;

  control_unit_mc #(.MUL_LATENCY(L)) dut (
    .clk(clk), .arst(arst), .en(en), .flush(flush), .insert_bubble(insert_bubble),
    .opcode(opcode), .funct7(funct7), .alu_op(alu_op), .branch(branch),
    .mem_read(mem_read), .mem_2_reg(mem_2_reg), .mem_write(mem_write),
    .alu_src(alu_src), .reg_write(reg_write), .jump(jump), .valid_ex(valid_ex),
    .illegal(illegal), .mul_start(mul_start), .mul_done(mul_done), .stall(stall)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] dut_bundle();
    return {alu_src, mem_2_reg, reg_write, mem_read, mem_write, branch, alu_op, jump};
  endfunction

  function automatic logic [8:0] spec_ctrl(input logic [6:0] op);
    case (op)
      OP_R:    return B_R;
      OP_I:    return B_I;
      OP_BEQ:  return 9'b0_0_0_0_0_1_01_0;
      OP_JAL:  return 9'b0_1_1_0_0_0_00_1;
      OP_LD:   return B_LD;
      OP_ST:   return B_ST;
      default: return B_BAD;
    endcase
  endfunction

  function automatic bit spec_legal(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_BEQ, OP_JAL, OP_LD, OP_ST};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: m_age counts EX cycles since a MUL was latched (0 = no MUL in EX).
  logic [8:0] m_bundle;
  logic       m_valid, m_illegal;
  int         m_age;

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      m_bundle <= '0; m_valid <= 1'b0; m_illegal <= 1'b0; m_age <= 0;
    end else if (flush) begin
      m_bundle <= '0; m_valid <= 1'b0; m_illegal <= 1'b0; m_age <= 0;
    end else if (EXT && m_age >= 1 && m_age <= L - 2) begin
      m_illegal <= 1'b0; m_age <= m_age + 1;
    end else if (!en) begin
      m_illegal <= 1'b0;
      if (m_age > 0 && m_age < 100) m_age <= m_age + 1;
    end else if (insert_bubble) begin
      m_bundle <= '0; m_valid <= 1'b0; m_illegal <= 1'b0; m_age <= 0;
    end else begin
      m_bundle  <= spec_ctrl(opcode);
      m_valid   <= spec_legal(opcode);
      m_illegal <= !spec_legal(opcode);
      m_age     <= (EXT && opcode == OP_R && funct7 == F7_MUL) ? 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("cyc_bundle", 16'(dut_bundle()), 16'(m_bundle));
      chk("cyc_valid", 16'(valid_ex), 16'(m_valid));
      chk("cyc_illegal", 16'(illegal), 16'(m_illegal));
      chk("cyc_mul_start", 16'(mul_start), 16'(m_age == 1));
      chk("cyc_mul_done", 16'(mul_done), 16'(m_age == ((L > 1) ? L - 1 : 1)));
      chk("cyc_stall", 16'(stall), 16'(m_age >= 1 && m_age <= L - 1));
    end
  end

  task automatic drv(input logic [6:0] op, input logic [6:0] f7, input logic e,
                     input logic bub, input logic fl);
    opcode = op; funct7 = f7; en = e; insert_bubble = bub; flush = fl;
    $display("txn t=%0t opcode=%b funct7=%b en=%b bubble=%b flush=%b", $time, op, f7, e, bub, fl);
  endtask

  initial begin
    int stalls;
    int dones;
    arst = 1'b1; en = 1'b0; flush = 1'b0; insert_bubble = 1'b0;
    opcode = '0; funct7 = '0;
    @(negedge clk);
    cmp_on = 1'b1;
    chk("reset_outputs", {2'b0, dut_bundle(), valid_ex, illegal, mul_start, mul_done, stall}, 16'h0);
    @(negedge clk);
    arst = 1'b0;
    drv(OP_LD, 7'd0, 1, 0, 0);
    @(negedge clk);
    chk("load_bundle", 16'(dut_bundle()), 16'(B_LD));
    chk("load_valid", 16'(valid_ex), 16'd1);

    // Every legal opcode once
    drv(OP_I, 7'd0, 1, 0, 0);   @(negedge clk);
    drv(OP_BEQ, 7'd0, 1, 0, 0); @(negedge clk);
    drv(OP_JAL, 7'd0, 1, 0, 0); @(negedge clk);
    drv(OP_ST, 7'd0, 1, 0, 0);  @(negedge clk);
    drv(OP_R, 7'd0, 1, 0, 0);   @(negedge clk);

    // Single MUL
    drv(OP_R, F7_MUL, 1, 0, 0);
    @(negedge clk);
    chk("mul_start_c1", 16'(mul_start), 16'(EXT));
    chk("mul_stall_c1", 16'(stall), 16'(EXT));
    drv(OP_I, 7'd0, 1, 0, 0);
    @(negedge clk);
    chk("mul_stall_c2", 16'(stall), 16'(EXT));
    @(negedge clk);
    chk("mul_done_c3", 16'(mul_done), 16'(EXT));
    chk("mul_bundle_c3", 16'(dut_bundle()), 16'(EXT ? B_R : B_I));
    @(negedge clk);
    chk("mul_stall_c4", 16'(stall), 16'd0);
    chk("mul_next_c4", 16'(dut_bundle()), 16'(B_I));

    // Back-to-back MULs: second one waits in ID
    drv(OP_R, F7_MUL, 1, 0, 0);
    stalls = 0; dones = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      stalls += int'(stall);
      dones  += int'(mul_done);
      if (i == 4) begin
        chk("b2b_second_start", 16'(mul_start), 16'(EXT));
        drv(OP_I, 7'd0, 1, 0, 0);
      end
    end
    chk("b2b_stall_cycles", 16'(stalls), 16'(EXT ? 6 : 0));
    chk("b2b_done_count", 16'(dones), 16'(EXT ? 2 : 0));

    // Flush in cycle 2 of a MUL
    drv(OP_R, F7_MUL, 1, 0, 0);
    dones = 0;
    @(negedge clk); dones += int'(mul_done); drv(OP_I, 7'd0, 1, 0, 0);
    @(negedge clk); dones += int'(mul_done); drv(OP_I, 7'd0, 1, 0, 1);
    @(negedge clk); dones += int'(mul_done);
    chk("flush_bundle", 16'(dut_bundle()), 16'(B_ZERO));
    chk("flush_valid", 16'(valid_ex), 16'd0);
    chk("flush_stall", 16'(stall), 16'd0);
    drv(OP_I, 7'd0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); dones += int'(mul_done);
    end
    chk("flush_no_done", 16'(dones), 16'd0);

    // en low holds; bubble zeroes; unknown opcode flags illegal
    drv(OP_I, 7'd0, 1, 0, 0);
    @(negedge clk); drv(OP_ST, 7'd0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("en_hold_bundle", 16'(dut_bundle()), 16'(B_I));
    drv(OP_ST, 7'd0, 1, 0, 0);
    @(negedge clk);
    chk("store_bundle", 16'(dut_bundle()), 16'(B_ST));
    drv(OP_LD, 7'd0, 1, 1, 0);
    @(negedge clk);
    chk("bubble_bundle", 16'(dut_bundle()), 16'(B_ZERO));
    chk("bubble_valid", 16'(valid_ex), 16'd0);
    drv(OP_BAD, 7'd0, 1, 0, 0);
    @(negedge clk);
    chk("illegal_pulse", 16'(illegal), 16'd1);
    chk("illegal_bundle", 16'(dut_bundle()), 16'(B_BAD));
    chk("illegal_valid", 16'(valid_ex), 16'd0);
    drv(OP_I, 7'd0, 1, 0, 0);
    @(negedge clk);
    chk("illegal_drop", 16'(illegal), 16'd0);

    // en low during BUSY: counter still runs
    drv(OP_R, F7_MUL, 1, 0, 0);
    @(negedge clk); drv(OP_I, 7'd0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("en_low_busy_done", 16'(mul_done), 16'(EXT));
    @(negedge clk);
    chk("en_low_busy_end", 16'(stall), 16'd0);
    chk("en_low_busy_bundle", 16'(dut_bundle()), 16'(B_R));
    drv(OP_I, 7'd0, 1, 0, 0);
    @(negedge clk);

    // Async reset in the middle of a MUL
    drv(OP_R, F7_MUL, 1, 0, 0);
    @(negedge clk); drv(OP_I, 7'd0, 1, 0, 0);
    @(negedge clk);
    #2 arst = 1'b1;
    #1 chk("midbusy_reset", {2'b0, dut_bundle(), valid_ex, illegal, mul_start, mul_done, stall}, 16'h0);
    @(negedge clk);
    arst = 1'b0;
    drv(OP_I, 7'd0, 1, 0, 0);
    @(negedge clk);
    chk("after_reset_bundle", 16'(dut_bundle()), 16'(B_I));
    @(negedge clk);
    cmp_on = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
